// File: rtl/add_rk.sv
// AES AddRoundKey: y = a ^ b, plus a registered valid/ready copy y_q.
// Ports: clk, reset (async, active-low), a/b in, y comb out,
//   in_valid/in_ready, y_q/out_valid/out_ready.
// Define ADDRK_SKID_EN for a 2-entry skid buffer with registered in_ready.
module add_rk #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] w_y;
  logic             w_acc;
  logic             w_con;
  logic [WIDTH-1:0] r_q;
  logic             r_vld;

  assign w_y       = a ^ b;
  assign y         = w_y;
  assign y_q       = r_q;
  assign out_valid = r_vld;
  assign w_acc     = in_valid & in_ready;
  assign w_con     = r_vld & out_ready;

`ifdef ADDRK_SKID_EN

  logic [WIDTH-1:0] r_tail;
  logic             r_tv;
  logic             r_rdy;
  logic [WIDTH-1:0] w_head_n;
  logic [WIDTH-1:0] w_tail_n;
  logic             w_hv_n;
  logic             w_tv_n;

  assign in_ready = r_rdy;

  always_comb begin
    w_head_n = r_q;
    w_tail_n = r_tail;
    w_hv_n   = r_vld;
    w_tv_n   = r_tv;
    unique case (1'b1)
      // consume with tail full: tail slides into head
      (w_con & r_tv): begin
        w_head_n = r_tail;
        w_tv_n   = w_acc;
        if (w_acc) w_tail_n = w_y;
      end
      (w_con & ~r_tv & w_acc): begin
        w_head_n = w_y;
      end
      (w_con & ~r_tv & ~w_acc): begin
        w_hv_n = 1'b0;
      end
      // head stalled: new data parks in tail
      (~w_con & w_acc & r_vld): begin
        w_tail_n = w_y;
        w_tv_n   = 1'b1;
      end
      (~w_con & w_acc & ~r_vld): begin
        w_head_n = w_y;
        w_hv_n   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q    <= '0;
      r_vld  <= 1'b0;
      r_tail <= '0;
      r_tv   <= 1'b0;
      r_rdy  <= 1'b0;
    end else begin
      r_q    <= w_head_n;
      r_vld  <= w_hv_n;
      r_tail <= w_tail_n;
      r_tv   <= w_tv_n;
      r_rdy  <= ~(w_hv_n & w_tv_n);
    end
  end

`else

  // r_live keeps in_ready low until the first edge after reset release
  logic r_live;

  assign in_ready = r_live & (~r_vld | out_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_live <= 1'b0;
      r_vld  <= 1'b0;
      r_q    <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_acc) begin
        r_q   <= w_y;
        r_vld <= 1'b1;
      end else if (w_con) begin
        r_vld <= 1'b0;
      end
    end
  end

`endif

endmodule

// File: tb/tb_add_rk.sv
// Directed bench for add_rk: FIPS vector, identities, reset,
// back-pressure, throughput and random handshake vs a queue model.
module tb_add_rk;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] a, b;
  logic [127:0] y, y_q;
  logic         in_valid, in_ready;
  logic         out_valid, out_ready;

  int checks = 0;
  int errors = 0;
  logic [127:0] q[$];
  logic live = 1'b0;
  logic last_acc, last_con;

  add_rk #(.WIDTH(128)) dut (
    .clk(clk), .reset(reset),
    .a(a), .b(b), .y(y),
    .in_valid(in_valid), .in_ready(in_ready),
    .y_q(y_q), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic exp_rdy();
`ifdef ADDRK_SKID_EN
    return live & (q.size() < 2);
`else
    return live & ((q.size() == 0) | out_ready);
`endif
  endfunction

  // one clock with model checks before the edge
  task automatic tick();
    #1;
    chk("y", y, a ^ b);
    chk("out_valid", {127'd0, out_valid},
        {127'd0, q.size() != 0});
    chk("in_ready", {127'd0, in_ready},
        {127'd0, exp_rdy()});
    if (q.size() != 0) chk("y_q", y_q, q[0]);
    last_acc = in_valid & in_ready;
    last_con = out_valid & out_ready;
    @(posedge clk);
    if (last_con && q.size() != 0) void'(q.pop_front());
    if (last_acc) q.push_back(a ^ b);
    if (reset) live = 1'b1;
    #1;
  endtask

  localparam logic [127:0] FA =
    128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FB =
    128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FY =
    128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] IB =
    128'h0123456789abcdeffedcba9876543210;

  initial begin
    logic [127:0] v[3];
    int k, nacc, ncon, budget;

    reset = 1'b0;
    a = '0; b = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_yq", y_q, '0);
    chk("rst_ov", {127'd0, out_valid}, '0);
    chk("rst_ir", {127'd0, in_ready}, '0);
    reset = 1'b1;
    tick();

    // FIPS-197 round 0
    a = FA; b = FB; in_valid = 1'b1;
    #1 chk("fips_y", y, FY);
    tick();
    chk("fips_yq", y_q, FY);
    chk("fips_ov", {127'd0, out_valid}, 128'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("drain_ov", {127'd0, out_valid}, '0);
    chk("hold_yq", y_q, FY);

    // identities
    a = '1; b = '1;
    #1 chk("id_ones", y, '0);
    a = '0; b = IB;
    #1 chk("id_zero", y, IB);
    a = IB; b = IB;
    #1 chk("id_same", y, '0);

    // back-pressure
    v[0] = 128'h11; v[1] = 128'h2200; v[2] = 128'h330000;
    b = 128'h0f; out_ready = 1'b0; k = 0; nacc = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = (k < 3);
      a = (k < 3) ? v[k] : '0;
      tick();
      if (last_acc) begin k++; nacc++; end
    end
`ifdef ADDRK_SKID_EN
    chk("bp_nacc", 128'(nacc), 128'd2);
`else
    chk("bp_nacc", 128'(nacc), 128'd1);
`endif
    out_ready = 1'b1; budget = 0;
    while ((k < 3 || q.size() != 0) && budget < 20) begin
      in_valid = (k < 3);
      a = (k < 3) ? v[k] : '0;
      tick();
      if (last_acc) k++;
      budget++;
    end
    in_valid = 1'b0;
    chk("bp_done", 128'(k), 128'd3);
    chk("bp_empty", 128'(q.size()), '0);

    // async reset mid-stall
    a = 128'hdead; b = 128'hbeef;
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    chk("ar_yq", y_q, '0);
    chk("ar_ov", {127'd0, out_valid}, '0);
    chk("ar_ir", {127'd0, in_ready}, '0);
    chk("ar_y", y, 128'hdead ^ 128'hbeef);
    q.delete();
    live = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    live = 1'b1;
    #1;

    // throughput
    in_valid = 1'b1; out_ready = 1'b1;
    ncon = 0;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) in_valid = 1'b0;
      a = rnd(); b = rnd();
      tick();
      if (i >= 1 && last_con) ncon++;
    end
    chk("tput", 128'(ncon), 128'd16);

    // random handshake
    for (int i = 0; i < 1000; i++) begin
      a = rnd(); b = rnd();
      in_valid = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; budget = 0;
    while (q.size() != 0 && budget < 10) begin
      tick();
      budget++;
    end
    chk("rnd_empty", 128'(q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
